// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module : uart_pkg
// Shared state type, framing constants and vote helper for the uart_v2 receiver.
// Rev    : 1.0  initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    localparam int SAMPLES_PER_BIT = 4;
    localparam int VOTE_PHASE      = 2;
    localparam int DATA_BITS       = 8;

    // 50 MHz / 109 gives four samples per bit at ~114.7 kbps (115200 - 0.45%)
    localparam int CLK_DIV_DEFAULT = 109;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_tick.sv
`default_nettype none
// ============================================================================
// Module : uart_baud_tick
// Quarter-bit sample tick divider; one-cycle tick every CLK_DIV sysclk cycles.
// Rev    : 1.0  initial release
// ============================================================================
module uart_baud_tick #(
    parameter int CLK_DIV = 109
) (
    input  logic sysclk,
    input  logic sysreset,
    input  logic clear,
    output logic tick
);

    localparam int              c_cnt_w = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(CLK_DIV - 1);

    logic [c_cnt_w-1:0] r_count;

    // clear outranks the count so a new frame always starts from a full period
    always_ff @(posedge sysclk) begin
        if (sysreset) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (r_count == c_last) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    assign tick = (r_count == c_last);

endmodule
`default_nettype wire

// File: rtl/uart_v2_rx.sv
`default_nettype none
// ============================================================================
// Module : uart_v2_rx
// 8N1 receiver: 4x oversampled, 2-of-3 majority vote, data/flag register pair.
// Rev    : 1.0  initial release
// ============================================================================
module uart_v2_rx #(
    parameter int CLK_DIV   = uart_pkg::CLK_DIV_DEFAULT,
    parameter int DATA_BITS = uart_pkg::DATA_BITS
) (
    input  logic                 sysclk,
    input  logic                 sysreset,
    input  logic                 rx_line,
    input  logic                 ack,
    output logic [DATA_BITS-1:0] parallel_out,
    output logic                 data_ready,
    output logic                 framing_err,
    output logic                 overrun,
    output logic                 rx_busy
);

    import uart_pkg::*;

    localparam int c_phase_w = $clog2(SAMPLES_PER_BIT);
    localparam int c_bit_w   = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [1:0] c_st_idle  = IDLE;
    localparam logic [1:0] c_st_start = START;
    localparam logic [1:0] c_st_data  = DATA;
    localparam logic [1:0] c_st_stop  = STOP;

    localparam logic [c_phase_w-1:0] c_ph_first  = '0;
    localparam logic [c_phase_w-1:0] c_ph_second = c_phase_w'(1);
    localparam logic [c_phase_w-1:0] c_ph_vote   = c_phase_w'(VOTE_PHASE);
    localparam logic [c_phase_w-1:0] c_ph_last   = c_phase_w'(SAMPLES_PER_BIT - 1);
    localparam logic [c_bit_w-1:0]   c_last_bit  = c_bit_w'(DATA_BITS - 1);

    logic                 r_sync1;
    logic                 r_rx_s;
    logic                 r_rx_prev;
    logic [1:0]           r_state;
    logic [1:0]           w_state_nxt;
    logic [c_phase_w-1:0] r_phase;
    logic [c_bit_w-1:0]   r_bit_cnt;
    logic                 r_samp0;
    logic                 r_samp1;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_ready;
    logic                 r_ferr;
    logic                 r_ovr;
    logic                 r_busy;

    logic w_tick;
    logic w_idle;
    logic w_detect;
    logic w_vote;
    logic w_vote_tick;
    logic w_end_tick;
    logic w_deliver;

    // Divider is held at zero while idle, so the first tick lands CLK_DIV after detect
    uart_baud_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_baud_tick (
        .sysclk   (sysclk),
        .sysreset (sysreset),
        .clear    (w_idle),
        .tick     (w_tick)
    );

    always_ff @(posedge sysclk) begin
        if (sysreset) begin
            r_sync1   <= 1'b1;
            r_rx_s    <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_sync1   <= rx_line;
            r_rx_s    <= r_sync1;
            r_rx_prev <= r_rx_s;
        end
    end

    assign w_idle      = (r_state == c_st_idle);
    assign w_detect    = w_idle && !r_rx_s && r_rx_prev;
    assign w_vote      = majority3(r_samp0, r_samp1, r_rx_s);
    assign w_vote_tick = w_tick && (r_phase == c_ph_vote);
    assign w_end_tick  = w_tick && (r_phase == c_ph_last);
    assign w_deliver   = w_vote_tick && (r_state == c_st_stop);

    // STOP leaves on its vote tick rather than phase 3 to tolerate fast senders
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: begin
                if (w_detect) w_state_nxt = c_st_start;
            end
            c_st_start: begin
                if (w_vote_tick && w_vote) begin
                    w_state_nxt = c_st_idle;
                end else if (w_end_tick) begin
                    w_state_nxt = c_st_data;
                end
            end
            c_st_data: begin
                if (w_end_tick && (r_bit_cnt == c_last_bit)) w_state_nxt = c_st_stop;
            end
            c_st_stop: begin
                if (w_vote_tick) w_state_nxt = c_st_idle;
            end
            default: w_state_nxt = c_st_idle;
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (sysreset) begin
            r_state <= c_st_idle;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt != c_st_idle);
        end
    end

    always_ff @(posedge sysclk) begin
        if (sysreset) begin
            r_phase   <= '0;
            r_bit_cnt <= '0;
            r_samp0   <= 1'b1;
            r_samp1   <= 1'b1;
            r_shift   <= '0;
        end else if (w_idle) begin
            r_phase   <= '0;
            r_bit_cnt <= '0;
        end else if (w_tick) begin
            r_phase <= r_phase + 1'b1;
            if (r_phase == c_ph_first)  r_samp0 <= r_rx_s;
            if (r_phase == c_ph_second) r_samp1 <= r_rx_s;
            if ((r_state == c_st_data) && (r_phase == c_ph_vote)) begin
                r_shift <= {w_vote, r_shift[DATA_BITS-1:1]};
            end
            if ((r_state == c_st_data) && (r_phase == c_ph_last)) begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end
        end
    end

    // A delivery coinciding with ack wins; ack only suppresses the overrun
    always_ff @(posedge sysclk) begin
        if (sysreset) begin
            r_data  <= '0;
            r_ready <= 1'b0;
            r_ferr  <= 1'b0;
            r_ovr   <= 1'b0;
        end else if (w_deliver) begin
            r_data  <= r_shift;
            r_ready <= 1'b1;
            r_ferr  <= ~w_vote;
            r_ovr   <= r_ovr | (r_ready & ~ack);
        end else if (ack) begin
            r_ready <= 1'b0;
            r_ferr  <= 1'b0;
            r_ovr   <= 1'b0;
        end
    end

    assign parallel_out = r_data;
    assign data_ready   = r_ready;
    assign framing_err  = r_ferr;
    assign overrun      = r_ovr;
    assign rx_busy      = r_busy;

endmodule
`default_nettype wire
